// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC generation, req/gnt issue to imem, in-order
// response capture into a DEPTH-entry queue, redirect with stale-response discard.

module fetch_queue_slot #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wpc,
  input  logic [DW-1:0] wdata,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] data
);
  // Payload only: occupancy lives in the parent's pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (we) begin
      pc   <= wpc;
      data <= wdata;
    end
  end
endmodule

module fetch_queue #(
  parameter int            AW         = 32,
  parameter int            DW         = 32,
  parameter logic [AW-1:0] RESET_ADDR = '0,
  parameter int            INC        = 4,
  parameter int            DEPTH      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          br_en,
  input  logic          br_z,
  input  logic          br_ne,
  input  logic [AW-1:0] br_addr,
  input  logic          jmp,
  input  logic [AW-1:0] jmp_addr,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  output logic          inst_valid,
  output logic [DW-1:0] inst_data,
  output logic [AW-1:0] inst_pc,
  input  logic          inst_ready,
  output logic [AW-1:0] pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] pc_r, rsp_pc, target;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, outstanding, discard;
  logic [CW:0]   inflight;
  logic          taken, redirect, credit_ok, accept, rsp, push, pop;

  logic [DEPTH-1:0][AW-1:0] slot_pc;
  logic [DEPTH-1:0][DW-1:0] slot_data;
  logic [DEPTH-1:0]         slot_we;

  always_comb begin
    taken     = br_en & (br_z ^ br_ne);
    redirect  = jmp | taken;
    target    = jmp ? jmp_addr : br_addr;
    // Queue entries plus in-flight fetches may never exceed DEPTH, so a
    // returning response always has a free slot.
    inflight  = {1'b0, count} + {1'b0, outstanding};
    credit_ok = inflight < (CW+1)'(DEPTH);
    imem_req  = !reset & !redirect & credit_ok;
    imem_addr = pc_r;
    pc        = pc_r;
    accept    = imem_req & imem_gnt;
    // An rvalid with nothing outstanding is protocol noise and is ignored.
    rsp       = imem_rvalid & (outstanding != '0);
    push      = rsp & (discard == '0) & !redirect & !reset;
    inst_valid = (count != '0) & !redirect & !reset;
    pop       = inst_valid & inst_ready;
    inst_pc   = slot_pc[rd_ptr];
    inst_data = slot_data[rd_ptr];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign slot_we[i] = push && (wr_ptr == PW'(i));
    fetch_queue_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk  (clk),
      .we   (slot_we[i]),
      .wpc  (rsp_pc),
      .wdata(imem_rdata),
      .pc   (slot_pc[i]),
      .data (slot_data[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r        <= RESET_ADDR;
      rsp_pc      <= RESET_ADDR;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect) begin
      // Everything still in flight belongs to the old path and must be dropped.
      pc_r        <= target;
      rsp_pc      <= target;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding - CW'(rsp);
      discard     <= outstanding - CW'(rsp);
    end else begin
      if (accept) pc_r <= pc_r + AW'(INC);
      outstanding <= outstanding + CW'(accept) - CW'(rsp);
      if (rsp && discard != '0) discard <= discard - CW'(1);
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        rsp_pc <= rsp_pc + AW'(INC);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule
